// File: rtl/oam_dma_controller.sv
// OAM DMA controller.
// A CPU write to the DMA register halts the CPU, aligns to an even (get)
// cycle, then moves XFER_COUNT bytes from page {page,00..} into the PPU
// OAMDATA register as alternating read/write cycle pairs.
module oam_dma_controller #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [2:0]  OAM_DATA_REG = 3'h4,
  // Bytes per transfer, 1..256. The index is 8 bits wide, so the
  // transfer never leaves the selected page.
  parameter int          XFER_COUNT   = 256
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] CPU_ADDR,
  input  logic [7:0]  CPU_DATA_IN,
  input  logic        CPU_WRITE,
  output logic        CPU_HALT,
  output logic        DMA_ACTIVE,
  output logic [15:0] DMA_ADDR,
  output logic        DMA_RD,
  input  logic [7:0]  DMA_RDATA,
  output logic [2:0]  PPU_ADDR,
  output logic [7:0]  PPU_DATA_OUT,
  output logic        PPU_WREN,
  output logic        CYCLE_ODD,
  output logic        DMA_DONE
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [7:0]  page_reg;
  logic [7:0]  idx_reg;
  logic        cycle_odd_reg;
  logic        done_reg;

  logic        trigger;
  logic        last_byte;

  // Only an idle controller listens to the DMA register; writes during a
  // transfer fall through untouched.
  assign trigger   = (state_reg == S_IDLE) && CPU_WRITE &&
                     (CPU_ADDR == DMA_REG_ADDR);
  assign last_byte = (idx_reg == LAST_IDX);

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. HALT decides whether an alignment cycle is needed so
  // that every READ lands on an even cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (trigger) begin
          state_next = S_HALT;
        end
      end
      S_HALT: begin
        if (cycle_odd_reg) begin
          state_next = S_READ;
        end else begin
          state_next = S_ALIGN;
        end
      end
      S_ALIGN: begin
        state_next = S_READ;
      end
      S_READ: begin
        state_next = S_WRITE;
      end
      S_WRITE: begin
        if (last_byte) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_READ;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Page latch and byte index: loaded by the trigger, stepped after each
  // write that is not the last one.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      page_reg <= 8'h00;
      idx_reg  <= 8'h00;
    end else if (trigger) begin
      page_reg <= CPU_DATA_IN;
      idx_reg  <= 8'h00;
    end else if ((state_reg == S_WRITE) && !last_byte) begin
      idx_reg  <= idx_reg + 8'h01;
    end
  end

  // Free-running get/put parity, zero in the first cycle out of reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cycle_odd_reg <= 1'b0;
    end else begin
      cycle_odd_reg <= ~cycle_odd_reg;
    end
  end

  // Completion pulse in the cycle following the final write; a reset
  // mid-transfer never reaches the final write, so no pulse is produced.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= (state_reg == S_WRITE) && last_byte;
    end
  end

  // Output decode. Everything is forced low while RESET is high so the
  // bus is released in the very cycle reset is applied.
  always_comb begin
    CPU_HALT     = 1'b0;
    DMA_ACTIVE   = 1'b0;
    DMA_ADDR     = 16'h0000;
    DMA_RD       = 1'b0;
    PPU_ADDR     = 3'h0;
    PPU_DATA_OUT = 8'h00;
    PPU_WREN     = 1'b0;
    if (!RESET) begin
      case (state_reg)
        S_HALT, S_ALIGN: begin
          CPU_HALT   = 1'b1;
          DMA_ACTIVE = 1'b1;
        end
        S_READ: begin
          CPU_HALT   = 1'b1;
          DMA_ACTIVE = 1'b1;
          DMA_RD     = 1'b1;
          DMA_ADDR   = {page_reg, idx_reg};
        end
        S_WRITE: begin
          CPU_HALT     = 1'b1;
          DMA_ACTIVE   = 1'b1;
          PPU_WREN     = 1'b1;
          PPU_ADDR     = OAM_DATA_REG;
          PPU_DATA_OUT = DMA_RDATA;
        end
        default: begin
          CPU_HALT   = 1'b0;
          DMA_ACTIVE = 1'b0;
        end
      endcase
    end
  end

  assign CYCLE_ODD = cycle_odd_reg & ~RESET;
  assign DMA_DONE  = done_reg & ~RESET;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for the OAM DMA controller: cycle timing, data path,
// ignored re-triggers, reset abort and back-to-back triggering.
module tb_oam_dma_controller;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] CPU_ADDR = 16'h0000;
  logic [7:0]  CPU_DATA_IN = 8'h00;
  logic        CPU_WRITE = 1'b0;
  logic        CPU_HALT;
  logic        DMA_ACTIVE;
  logic [15:0] DMA_ADDR;
  logic        DMA_RD;
  logic [7:0]  rdata = 8'h00;
  logic [2:0]  PPU_ADDR;
  logic [7:0]  PPU_DATA_OUT;
  logic        PPU_WREN;
  logic        CYCLE_ODD;
  logic        DMA_DONE;

  oam_dma_controller dut (
    .CLK(CLK), .RESET(RESET), .CPU_ADDR(CPU_ADDR), .CPU_DATA_IN(CPU_DATA_IN),
    .CPU_WRITE(CPU_WRITE), .CPU_HALT(CPU_HALT), .DMA_ACTIVE(DMA_ACTIVE),
    .DMA_ADDR(DMA_ADDR), .DMA_RD(DMA_RD), .DMA_RDATA(rdata),
    .PPU_ADDR(PPU_ADDR), .PPU_DATA_OUT(PPU_DATA_OUT), .PPU_WREN(PPU_WREN),
    .CYCLE_ODD(CYCLE_ODD), .DMA_DONE(DMA_DONE)
  );

  always #5 CLK = ~CLK;

  wire [32:0] all_out = {CPU_HALT, DMA_ACTIVE, DMA_ADDR, DMA_RD, PPU_ADDR,
                         PPU_DATA_OUT, PPU_WREN, CYCLE_ODD, DMA_DONE};

  // Source memory: page $07 holds nn^$A5, other pages hold nn^page.
  function automatic logic [7:0] src_byte(input logic [15:0] a);
    if (a[15:8] == 8'h07) return a[7:0] ^ 8'hA5;
    return a[7:0] ^ a[15:8];
  endfunction

  // Bus read responder: data valid in the cycle after the read strobe.
  always @(posedge CLK) begin
    if (DMA_RD) rdata <= src_byte(DMA_ADDR);
  end

  // Cycle number since reset release (0 = first cycle out of reset).
  int cyc = 0;
  always @(posedge CLK) begin
    if (RESET) cyc <= 0;
    else cyc <= cyc + 1;
  end

  int n_cmp = 0;
  int n_fail = 0;

  // Statistics gathered by capture().
  int halt_cnt, halt_first, halt_last, rd_cnt, first_rd_cyc, wr_cnt;
  int last_wr_cyc, done_cnt, done_cyc;
  int bad_addr, bad_data, even_wr, bad_ppu, stray, par_err, act_err;
  logic [15:0] first_rd_addr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1; CPU_WRITE = 1'b0; CPU_ADDR = 16'h0; CPU_DATA_IN = 8'h0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    #1;
  endtask

  task automatic trigger_at(input int target, input logic [7:0] pg);
    for (int g = 0; g < 2000 && cyc != target; g++) @(negedge CLK);
    CPU_WRITE = 1'b1; CPU_ADDR = 16'h4014; CPU_DATA_IN = pg;
  endtask

  // Observes the DUT cycle by cycle, sampling at the falling edge.
  task automatic capture(input logic [7:0] pg, input int budget,
                         input int retrig_wr, input int stop_wr,
                         input bit stop_on_done);
    logic [7:0] exp_d;
    halt_cnt = 0; halt_first = -1; halt_last = -1; rd_cnt = 0;
    first_rd_cyc = -1; first_rd_addr = 16'hFFFF; wr_cnt = 0;
    last_wr_cyc = -1; done_cnt = 0; done_cyc = -1; bad_addr = 0;
    bad_data = 0; even_wr = 0; bad_ppu = 0; stray = 0; par_err = 0;
    act_err = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge CLK);
      CPU_WRITE = 1'b0; CPU_ADDR = 16'h0; CPU_DATA_IN = 8'h0;
      if (CYCLE_ODD !== cyc[0]) par_err++;
      if (CPU_HALT !== DMA_ACTIVE) act_err++;
      if (CPU_HALT === 1'b1) begin
        if (halt_cnt == 0) halt_first = cyc;
        halt_last = cyc;
        halt_cnt++;
      end
      if (DMA_RD === 1'b1) begin
        if (rd_cnt == 0) begin
          first_rd_cyc = cyc;
          first_rd_addr = DMA_ADDR;
        end
        if (DMA_ADDR !== {pg, rd_cnt[7:0]}) bad_addr++;
        rd_cnt++;
      end else if (DMA_ADDR !== 16'h0) stray++;
      if (PPU_WREN === 1'b1) begin
        if (CYCLE_ODD !== 1'b1) even_wr++;
        if (PPU_ADDR !== 3'h4) bad_ppu++;
        exp_d = src_byte({pg, wr_cnt[7:0]});
        if (PPU_DATA_OUT !== exp_d) bad_data++;
        last_wr_cyc = cyc;
        wr_cnt++;
        if (retrig_wr > 0 && wr_cnt == retrig_wr) begin
          CPU_WRITE = 1'b1; CPU_ADDR = 16'h4014; CPU_DATA_IN = 8'h03;
        end
      end else if (PPU_ADDR !== 3'h0 || PPU_DATA_OUT !== 8'h0) stray++;
      if (DMA_DONE === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        if (CPU_HALT !== 1'b0) stray++;
      end
      if (stop_on_done && DMA_DONE === 1'b1) break;
      if (stop_wr > 0 && wr_cnt == stop_wr) break;
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RESET = 1'b1; CPU_WRITE = 1'b1; CPU_ADDR = 16'h4014; CPU_DATA_IN = 8'h09;
    #1;
    n_cmp++; if (all_out !== 33'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    @(negedge CLK);
    n_cmp++; if (all_out !== 33'h0) begin n_fail++; $display("FAIL reset_hold: got %h want 0", all_out); end
    CPU_WRITE = 1'b0; CPU_ADDR = 16'h0; CPU_DATA_IN = 8'h0;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    n_cmp++; if (all_out !== 33'h0) begin n_fail++; $display("FAIL release_cycle: got %h want 0", all_out); end
    @(negedge CLK);
    n_cmp++; if (CYCLE_ODD !== 1'b1) begin n_fail++; $display("FAIL parity_cycle1: got %b want 1", CYCLE_ODD); end
    CPU_WRITE = 1'b1; CPU_ADDR = 16'h4015; CPU_DATA_IN = 8'h02;
    @(negedge CLK);
    n_cmp++; if (CPU_HALT !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_trigger: halt %b want 0", CPU_HALT); end
    CPU_WRITE = 1'b0; CPU_ADDR = 16'h4014;
    @(negedge CLK);
    n_cmp++; if (CPU_HALT !== 1'b0) begin n_fail++; $display("FAIL read_not_trigger: halt %b want 0", CPU_HALT); end
    CPU_ADDR = 16'h0; CPU_DATA_IN = 8'h0;
    $display("test_reset: done");
  endtask

  task automatic test_even_trigger();
    do_reset();
    trigger_at(4, 8'h02);
    capture(8'h02, 530, 0, 0, 0);
    n_cmp++; if (halt_first !== 5) begin n_fail++; $display("FAIL even_halt_first: got %0d want 5", halt_first); end
    n_cmp++; if (first_rd_cyc !== 6) begin n_fail++; $display("FAIL even_first_read: got %0d want 6", first_rd_cyc); end
    n_cmp++; if (first_rd_addr !== 16'h0200) begin n_fail++; $display("FAIL even_first_addr: got %h want 0200", first_rd_addr); end
    n_cmp++; if (last_wr_cyc !== 517) begin n_fail++; $display("FAIL even_last_write: got %0d want 517", last_wr_cyc); end
    n_cmp++; if (done_cyc !== 518) begin n_fail++; $display("FAIL even_done_cycle: got %0d want 518", done_cyc); end
    n_cmp++; if (halt_cnt !== 513) begin n_fail++; $display("FAIL even_halt_count: got %0d want 513", halt_cnt); end
    n_cmp++; if (halt_last !== 517) begin n_fail++; $display("FAIL even_halt_last: got %0d want 517", halt_last); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL even_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (act_err !== 0) begin n_fail++; $display("FAIL even_active_eq_halt: got %0d want 0", act_err); end
    $display("test_even_trigger: page 02 halted %0d cycles, done at %0d", halt_cnt, done_cyc);
  endtask

  task automatic test_odd_trigger();
    do_reset();
    trigger_at(3, 8'h02);
    capture(8'h02, 530, 0, 0, 0);
    n_cmp++; if (halt_first !== 4) begin n_fail++; $display("FAIL odd_halt_first: got %0d want 4", halt_first); end
    n_cmp++; if (first_rd_cyc !== 6) begin n_fail++; $display("FAIL odd_first_read: got %0d want 6", first_rd_cyc); end
    n_cmp++; if (halt_cnt !== 514) begin n_fail++; $display("FAIL odd_halt_count: got %0d want 514", halt_cnt); end
    n_cmp++; if (done_cyc !== 518) begin n_fail++; $display("FAIL odd_done_cycle: got %0d want 518", done_cyc); end
    n_cmp++; if (stray !== 0) begin n_fail++; $display("FAIL odd_stray_outputs: got %0d want 0", stray); end
    $display("test_odd_trigger: halted %0d cycles from %0d", halt_cnt, halt_first);
  endtask

  task automatic test_data();
    do_reset();
    trigger_at(4, 8'h07);
    capture(8'h07, 530, 0, 0, 0);
    n_cmp++; if (wr_cnt !== 256) begin n_fail++; $display("FAIL data_write_count: got %0d want 256", wr_cnt); end
    n_cmp++; if (rd_cnt !== 256) begin n_fail++; $display("FAIL data_read_count: got %0d want 256", rd_cnt); end
    n_cmp++; if (bad_data !== 0) begin n_fail++; $display("FAIL data_values: got %0d bad want 0", bad_data); end
    n_cmp++; if (bad_addr !== 0) begin n_fail++; $display("FAIL data_addr_order: got %0d bad want 0", bad_addr); end
    n_cmp++; if (even_wr !== 0) begin n_fail++; $display("FAIL data_even_write: got %0d want 0", even_wr); end
    n_cmp++; if (bad_ppu !== 0) begin n_fail++; $display("FAIL data_ppu_addr: got %0d bad want 0", bad_ppu); end
    n_cmp++; if (stray !== 0) begin n_fail++; $display("FAIL data_stray_outputs: got %0d want 0", stray); end
    n_cmp++; if (par_err !== 0) begin n_fail++; $display("FAIL data_parity: got %0d errors want 0", par_err); end
    $display("test_data: page 07 wrote %0d bytes", wr_cnt);
  endtask

  task automatic test_ignored_retrigger();
    do_reset();
    trigger_at(4, 8'h07);
    capture(8'h07, 530, 100, 0, 0);
    n_cmp++; if (bad_addr !== 0) begin n_fail++; $display("FAIL retrig_page: got %0d bad addrs want 0", bad_addr); end
    n_cmp++; if (rd_cnt !== 256) begin n_fail++; $display("FAIL retrig_read_count: got %0d want 256", rd_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL retrig_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (done_cyc !== 518) begin n_fail++; $display("FAIL retrig_done_cycle: got %0d want 518", done_cyc); end
    n_cmp++; if (halt_cnt !== 513) begin n_fail++; $display("FAIL retrig_halt_count: got %0d want 513", halt_cnt); end
    $display("test_ignored_retrigger: %0d reads, %0d done pulses", rd_cnt, done_cnt);
  endtask

  task automatic test_reset_abort();
    do_reset();
    trigger_at(4, 8'h07);
    capture(8'h07, 600, 0, 50, 0);
    n_cmp++; if (wr_cnt !== 50) begin n_fail++; $display("FAIL abort_reach_byte50: got %0d want 50", wr_cnt); end
    RESET = 1'b1;
    @(negedge CLK);
    n_cmp++; if (all_out !== 33'h0) begin n_fail++; $display("FAIL abort_outputs: got %h want 0", all_out); end
    RESET = 1'b0;
    #1;
    n_cmp++; if (all_out !== 33'h0) begin n_fail++; $display("FAIL abort_release: got %h want 0", all_out); end
    trigger_at(4, 8'h07);
    capture(8'h07, 530, 0, 0, 0);
    n_cmp++; if (first_rd_addr !== 16'h0700) begin n_fail++; $display("FAIL abort_restart_addr: got %h want 0700", first_rd_addr); end
    n_cmp++; if (wr_cnt !== 256) begin n_fail++; $display("FAIL abort_restart_count: got %0d want 256", wr_cnt); end
    n_cmp++; if (bad_data !== 0) begin n_fail++; $display("FAIL abort_restart_data: got %0d bad want 0", bad_data); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL abort_restart_done: got %0d want 1", done_cnt); end
    $display("test_reset_abort: restart wrote %0d bytes", wr_cnt);
  endtask

  task automatic test_back_to_back();
    int first_done;
    do_reset();
    trigger_at(4, 8'h01);
    capture(8'h01, 530, 0, 0, 1);
    first_done = done_cyc;
    n_cmp++; if (first_done !== 518) begin n_fail++; $display("FAIL b2b_first_done: got %0d want 518", first_done); end
    CPU_WRITE = 1'b1; CPU_ADDR = 16'h4014; CPU_DATA_IN = 8'h05;
    capture(8'h05, 530, 0, 0, 0);
    n_cmp++; if (halt_first !== 519) begin n_fail++; $display("FAIL b2b_halt_next: got %0d want 519", halt_first); end
    n_cmp++; if (halt_cnt !== 513) begin n_fail++; $display("FAIL b2b_halt_count: got %0d want 513", halt_cnt); end
    n_cmp++; if (wr_cnt !== 256) begin n_fail++; $display("FAIL b2b_write_count: got %0d want 256", wr_cnt); end
    n_cmp++; if (bad_data !== 0) begin n_fail++; $display("FAIL b2b_data: got %0d bad want 0", bad_data); end
    n_cmp++; if (bad_addr !== 0) begin n_fail++; $display("FAIL b2b_addr: got %0d bad want 0", bad_addr); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 1", done_cnt); end
    $display("test_back_to_back: second transfer halted from %0d", halt_first);
  endtask

  initial begin
    test_reset();
    test_even_trigger();
    test_odd_trigger();
    test_data();
    test_ignored_retrigger();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
- Sequences the OAM DMA transfer triggered by a CPU write to $4014.
- Halts the CPU, then copies 256 bytes from CPU page $XX00–$XXFF into PPU OAM through the PPU OAMDATA register port (CPU_ADDR 3'h4).
- Sits between the CPU core, the CPU bus mux and the PPU CPU-register interface; owns the CPU bus while DMA_ACTIVE is high.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address whose write starts a transfer.
- OAM_DATA_REG, 3'h4, PPU register index written for each byte.
- XFER_COUNT, 256, bytes per transfer (1..256).

Ports:
- CLK  in  1  CPU-rate clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- CPU_ADDR  in  16  CPU bus address.
- CPU_DATA_IN  in  8  CPU write data; page number on a trigger write.
- CPU_WRITE  in  1  CPU write strobe for the current cycle.
- CPU_HALT  out  1  stalls the CPU core while high.
- DMA_ACTIVE  out  1  selects DMA as CPU bus master.
- DMA_ADDR  out  16  bus read address, {page, idx}.
- DMA_RD  out  1  bus read strobe.
- DMA_RDATA  in  8  read data, valid in the cycle after DMA_RD.
- PPU_ADDR  out  3  PPU register index.
- PPU_DATA_OUT  out  8  data to the PPU register.
- PPU_WREN  out  1  PPU register write strobe.
- CYCLE_ODD  out  1  cycle parity; 0 = read ("get") cycle.
- DMA_DONE  out  1  one-cycle pulse after the last byte.

Behaviour:
- Reset:
  - State returns to IDLE; page, idx and CYCLE_ODD clear to 0.
  - All outputs are 0 during reset and in the cycle after reset is released.
  - Reset mid-transfer aborts immediately, with no DMA_DONE pulse.
- Parity: CYCLE_ODD is 0 in the first cycle after RESET deasserts and toggles every cycle thereafter, including during DMA.
- Trigger:
  - Condition: state IDLE && CPU_WRITE && CPU_ADDR==DMA_REG_ADDR at a clock edge.
  - On trigger, latch page=CPU_DATA_IN and idx=0; next state HALT.
  - Trigger writes while not IDLE are ignored; the page is not updated.
- States:
  - IDLE: outputs 0.
  - HALT: CPU_HALT=1, DMA_ACTIVE=1, no bus activity, lasts 1 cycle. Next state is READ if the next cycle is even (CYCLE_ODD currently 1), else ALIGN.
  - ALIGN: CPU_HALT=1, DMA_ACTIVE=1, idle, lasts 1 cycle; next state READ.
  - READ (always an even cycle): DMA_RD=1, DMA_ADDR={page,idx}; next state WRITE.
  - WRITE (always an odd cycle): PPU_WREN=1, PPU_ADDR=OAM_DATA_REG, PPU_DATA_OUT=DMA_RDATA (combinational pass-through).
    - If idx==XFER_COUNT-1: next state IDLE and DMA_DONE=1 in the following cycle.
    - Otherwise idx+=1 and next state READ.
- CPU_HALT and DMA_ACTIVE are high from HALT through the final WRITE inclusive, and low in the DMA_DONE cycle.
- Total halted cycles = 1 + align + 2*XFER_COUNT, i.e. 513 or 514 for XFER_COUNT=256.
- Outputs not driven by the current state are 0: DMA_ADDR=0 outside READ, PPU_DATA_OUT=0 outside WRITE.
- A trigger may be accepted in the same cycle DMA_DONE is high (state is IDLE).
- idx is 8 bits; addressing never crosses the page, and DMA_ADDR[15:8]==page throughout.
- Registers are written only by the PPU_WREN strobe; the controller does not read the PPU.

Test Plan:
- Reset release; trigger write of $02 to $4014 sampled at cycle 4 (even) -> HALT at cycle 5, first READ at cycle 6 with DMA_ADDR=$0200, last WRITE at cycle 517, DMA_DONE=1 at cycle 518, CPU_HALT high for 513 cycles.
- Same trigger sampled at cycle 3 (odd) -> ALIGN at cycle 5, READ at cycle 6, CPU_HALT high for 514 cycles (4..517).
- Source memory model with mem[$07nn]=nn^$A5, page $07 -> exactly 256 PPU_WREN pulses, PPU_ADDR=4, the k-th pulse carries data k^$A5, DMA_ADDR runs $0700..$07FF in order, with no write on an even cycle.
- Second $4014 write of $03 at byte 100 of an active transfer -> ignored; the remaining addresses stay on page $07 and exactly one DMA_DONE pulse occurs.
- RESET asserted at byte 50 -> the next cycle shows IDLE with all outputs 0 and no DMA_DONE; a new trigger after release runs a full 256-byte transfer from idx 0.
- Trigger issued in the DMA_DONE cycle -> accepted; HALT follows in the next cycle.
